// File: rtl/cpu_pkg.sv
// cpu_pkg: shared branch funct3 codes, resolve-stage state encoding and reset PC.
package cpu_pkg;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_TRAP} state_t;
endpackage

// File: rtl/br_cond_dec.sv
// br_cond_dec: funct3 plus comparator flags to branch condition and compare mode.
module br_cond_dec
  import cpu_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       br_eq,
  input  logic       br_lt,
  output logic       cond,
  output logic       br_un
);
  always_comb begin
    br_un = (funct3 == F3_BLT) || (funct3 == F3_BGE);
    cond  = (funct3 == F3_BEQ) ? br_eq :
            (funct3 == F3_BNE) ? !br_eq :
            (funct3 == F3_BLT || funct3 == F3_BLTU) ? br_lt :
            (funct3 == F3_BGE || funct3 == F3_BGEU) ? !br_lt : 1'b0;
  end
endmodule

// File: rtl/br_resolve.sv
// br_resolve: branch resolution, fetch PC register, post-redirect flush and misaligned-target trap.
// Optional BR_RESOLVE_STATS_EN adds conditional-branch taken/total counters.
module br_resolve
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = RESET_PC_DEF,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  valid_in,
  input  logic                  is_branch,
  input  logic                  is_jal,
  input  logic                  is_jalr,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] pc_ex,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic                  BrEq,
  input  logic                  BrLt,
  output logic                  BrUn,
  output logic [DATA_WIDTH-1:0] pc_out,
  output logic                  redirect,
  output logic                  flush,
  output logic                  trap,
  output logic [DATA_WIDTH-1:0] trap_pc,
  input  logic                  trap_ack
`ifdef BR_RESOLVE_STATS_EN
  ,
  output logic [31:0]           br_taken_cnt,
  output logic [31:0]           br_total_cnt
`endif
);
  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(4);
  state_t state;
  logic [2:0] cnt;
  logic cond, active, taken;
  logic [DATA_WIDTH-1:0] target;
  br_cond_dec u_dec (
    .funct3(funct3),
    .br_eq (BrEq),
    .br_lt (BrLt),
    .cond  (cond),
    .br_un (BrUn)
  );
  always_comb begin
    active   = valid_in && !stall && state == ST_RUN;
    taken    = active && (is_jal || is_jalr || (is_branch && cond));
    target   = is_jalr ? ((rs1_data + imm) & ~DATA_WIDTH'(1)) : (pc_ex + imm);
    redirect = taken && target[1:0] == 2'b00;
  end
  // trap_ack is serviced ahead of the stall check so a stalled pipe can still leave TRAP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_out  <= RESET_PC;
      flush   <= 1'b0;
      trap    <= 1'b0;
      trap_pc <= '0;
      state   <= ST_RUN;
      cnt     <= '0;
    end else if (state == ST_TRAP) begin
      if (trap_ack) begin
        trap   <= 1'b0;
        pc_out <= RESET_PC;
        state  <= ST_RUN;
      end
    end else if (!stall) begin
      if (state == ST_FLUSH) begin
        pc_out <= pc_out + STEP;
        if (cnt == 3'd0) begin
          flush <= 1'b0;
          state <= ST_RUN;
        end else begin
          cnt <= cnt - 3'd1;
        end
      end else if (redirect) begin
        pc_out <= target;
        flush  <= 1'b1;
        cnt    <= CNT_INIT;
        state  <= (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;
      end else if (taken) begin
        flush   <= 1'b0;
        trap    <= 1'b1;
        trap_pc <= pc_ex;
        state   <= ST_TRAP;
      end else begin
        pc_out <= pc_out + STEP;
        flush  <= 1'b0;
      end
    end
  end
`ifdef BR_RESOLVE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_taken_cnt <= '0;
      br_total_cnt <= '0;
    end else if (active && is_branch) begin
      br_total_cnt <= br_total_cnt + 32'd1;
      br_taken_cnt <= br_taken_cnt + {31'd0, cond};
    end
  end
`endif
endmodule

// File: doc/br_resolve.md
Name: br_resolve

Overview:
- Branch-resolution and PC-update stage directly downstream of the branch comparator; consumes BrEq/BrLt and drives BrUn back into it.
- Decodes the EX-stage branch/jump and decides taken/not-taken, owns the fetch PC register, and issues the redirect.
- Sequences a multi-cycle pipeline flush after any redirect and traps misaligned targets.

Parameters:
- DATA_WIDTH, 32, datapath/PC width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FLUSH_CYCLES, 2, number of cycles flush is held after a redirect (1..7).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  pipeline stall; holds PC and freezes the state machine.
- valid_in  input  1  EX-stage instruction valid.
- is_branch  input  1  conditional branch in EX.
- is_jal  input  1  JAL in EX.
- is_jalr  input  1  JALR in EX.
- funct3  input  3  branch condition (RV32I encoding).
- pc_ex  input  DATA_WIDTH  PC of the EX instruction.
- imm  input  DATA_WIDTH  sign-extended immediate.
- rs1_data  input  DATA_WIDTH  rs1 operand (JALR base).
- BrEq  input  1  comparator equal.
- BrLt  input  1  comparator less-than.
- BrUn  output  1  compare mode to comparator: 1 = signed, 0 = unsigned.
- pc_out  output  DATA_WIDTH  current fetch PC (register).
- redirect  output  1  combinational; high when the EX instruction is taken this cycle.
- flush  output  1  registered; invalidates IF/ID.
- trap  output  1  misaligned-target trap pending.
- trap_pc  output  DATA_WIDTH  pc_ex of the faulting instruction.
- trap_ack  input  1  trap handler acknowledge.

Behaviour:
- Reset (asynchronous):
  - pc_out = RESET_PC; flush = 0; trap = 0; trap_pc = 0; state = RUN; flush count = 0.
- BrUn (combinational):
  - 1 for funct3 100/101 (BLT/BGE).
  - 0 for 110/111 (BLTU/BGEU).
  - Don't-care (drive 0) otherwise.
- Taken (combinational), evaluated only when valid_in & !stall & state==RUN:
  - BEQ (000): BrEq.
  - BNE (001): !BrEq.
  - BLT/BLTU: BrLt.
  - BGE/BGEU: !BrLt.
  - Undefined funct3 (010, 011): not taken.
  - JAL and JALR: always taken.
- Target:
  - Branch/JAL: pc_ex+imm.
  - JALR: (rs1_data+imm) & ~1.
  - All arithmetic is modulo 2^DATA_WIDTH; wrap-around is silent.
- States:
  - RUN: pc_out <= pc_out+4 each unstalled cycle.
    - If taken and target[1:0]==0: redirect=1, pc_out <= target, flush <= 1, count <= FLUSH_CYCLES-1, go to FLUSH (stay in RUN if FLUSH_CYCLES==1, flush drops the following cycle).
    - If taken and target[1:0]!=0: redirect=0, pc_out holds, trap <= 1, trap_pc <= pc_ex, go to TRAP.
  - FLUSH: flush stays 1; valid_in is ignored; pc_out increments by 4; count decrements each unstalled cycle. At count==0: flush <= 0, go to RUN.
  - TRAP: pc_out holds; valid_in is ignored. On trap_ack: trap <= 0, pc_out <= RESET_PC, go to RUN.
- stall=1:
  - No register changes except trap_ack handling, which is honoured even while stalled.
  - redirect is 0; the held EX instruction is re-evaluated when stall drops.
- Simultaneous events:
  - rst overrides everything.
  - A taken instruction arriving on the same cycle flush deasserts to RUN is evaluated normally (no lost branch).
- Latency: redirect in the resolve cycle; the new PC is visible on pc_out the next cycle; flush is high for exactly FLUSH_CYCLES unstalled cycles.

Optional Feature:
- BR_RESOLVE_STATS_EN defined: adds outputs br_taken_cnt and br_total_cnt (32 bits each). They count resolved conditional branches (taken, and total) in RUN, are cleared by rst, and wrap on overflow.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package `cpu_pkg`:
  - funct3 branch localparams (F3_BEQ … F3_BGEU).
  - State encoding (ST_RUN, ST_FLUSH, ST_TRAP).
  - RESET_PC default.
- One natural sub-module `br_cond_dec`: combinational funct3/BrEq/BrLt → taken and BrUn. The target adder and state machine stay in the top.

Test Plan:
- Reset mid-flush:
  - Assert rst during FLUSH → pc_out = 0, flush = 0 immediately (asynchronous).
  - Release rst → pc_out 0, 4, 8 on the following cycles.
- BEQ taken, conditional-branch path:
  - Stimulus: pc_ex = 0x100, imm = 0x40, BrEq = 1.
  - Response: redirect = 1 that cycle; pc_out = 0x140 next cycle; flush high for 2 cycles.
- BLTU not taken, unsigned compare mode:
  - Stimulus: funct3 = 110, BrLt = 0.
  - Response: BrUn = 0; no redirect; pc_out increments by 4.
- BLT signed compare mode:
  - Stimulus: funct3 = 100, BrLt = 1.
  - Response: BrUn = 1; redirect = 1.
- JALR target masking:
  - Stimulus: rs1_data = 0x203, imm = 1.
  - Response: target = 0x204; pc_out = 0x204.
- Misaligned JAL trap:
  - Stimulus: pc_ex = 0x10, imm = 2.
  - Response: trap = 1, trap_pc = 0x10, pc_out held.
  - After trap_ack → pc_out = RESET_PC, trap = 0.
- Stall during resolve:
  - Stimulus: stall = 1 with a taken BEQ present.
  - Response: redirect = 0, pc_out held.
  - Drop stall → redirect fires that cycle.
